goal_sprite_fetch: RTL and testbench

Address generator and pixel qualifier for the 105×110 goal sprite ROM. It sits between the VGA scan counters and the goal sprite ROM. Each cycle it converts the current scan position into a ROM read address, tracking rows incrementally so no multiplier is needed. It delays a hit flag to match the ROM's one-cycle read latency, then emits a registered palette index and an on-flag for the colour mapper. Goal position is latched once per frame, so the goal never tears mid-frame.

---
 rtl/goal_sprite_fetch.sv | 112 +++++++++++
 tb/tb_goal_sprite_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/goal_sprite_fetch.sv
// goal_sprite_fetch: converts the VGA scan position into a read address for the
// 105x110 goal sprite ROM and qualifies the returned palette index. Sprite rows
// are tracked incrementally (row_base += SPRITE_W per line), so no multiplier is
// needed. The goal position is latched once per frame, so the sprite never tears.
module goal_sprite_fetch #(
  parameter int SPRITE_W        = 105,
  parameter int SPRITE_H        = 110,
  parameter int ADDR_W          = 14,
  parameter int IDX_W           = 5,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        goal_x,
  input  logic [9:0]        goal_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pixel_valid,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              goal_on,
  output logic [IDX_W-1:0]  goal_index
);

  localparam logic [1:0] WAIT_TOP  = 2'd0;
  localparam logic [1:0] IN_SPRITE = 2'd1;
  localparam logic [1:0] BELOW     = 2'd2;

  logic [1:0]        state;
  logic [9:0]        gx_q;
  logic [9:0]        gy_q;
  logic [ADDR_W-1:0] row_base;
  logic [6:0]        row_cnt;
  logic              pv_q;
  logic              hit_d1;
  logic              hit_d2;

  logic [10:0]       dx;
  logic              col_hit;
  logic              top_row;
  logic              eol;
  logic              hit;
  logic              goal_on_next;

  // Column/row qualification of the current scan position.
  always_comb begin
    dx           = {1'b0, DrawX} - {1'b0, gx_q};
    col_hit      = (DrawX >= gx_q) && (dx < 11'(SPRITE_W));
    top_row      = (DrawY == gy_q);
    eol          = pv_q && !pixel_valid;
    hit          = pixel_valid && col_hit &&
                   ((state == IN_SPRITE) || ((state == WAIT_TOP) && top_row));
    goal_on_next = hit_d2 && (rom_data != IDX_W'(TRANSPARENT_IDX));
  end

  // Frame latch and row-tracking FSM; frame_start overrides everything else.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= BELOW;
      gx_q     <= '0;
      gy_q     <= '0;
      row_base <= '0;
      row_cnt  <= '0;
    end else if (frame_start) begin
      state    <= WAIT_TOP;
      gx_q     <= goal_x;
      gy_q     <= goal_y;
      row_base <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        WAIT_TOP: begin
          if (pixel_valid && top_row)
            state <= IN_SPRITE;
        end
        IN_SPRITE: begin
          if (eol) begin
            if (row_cnt == 7'(SPRITE_H - 1)) begin
              state <= BELOW;
            end else begin
              row_base <= row_base + ADDR_W'(SPRITE_W);
              row_cnt  <= row_cnt + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address register, hit delay line aligned to the ROM latency, and output stage.
  // hit_d2 is the flag that lines up with rom_data, giving the two-cycle latency.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      read_address <= '0;
      pv_q         <= 1'b0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      goal_on      <= 1'b0;
      goal_index   <= '0;
    end else begin
      read_address <= hit ? (row_base + ADDR_W'(dx)) : '0;
      pv_q         <= pixel_valid;
      hit_d1       <= hit;
      hit_d2       <= hit_d1;
      goal_on      <= goal_on_next;
      goal_index   <= goal_on_next ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_goal_sprite_fetch.sv
// Testbench for goal_sprite_fetch: a ROM model feeds rom_data, and a scoreboard
// computes the expected address/pixel directly from the sprite geometry
// ((y-gy)*W + (x-gx)) for every cycle, plus a table of hand-computed probes.
module tb_goal_sprite_fetch;

  localparam int W = 105;
  localparam int H = 110;

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  goal_x;
  logic [9:0]  goal_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pixel_valid;
  logic [13:0] read_address;
  logic [4:0]  rom_data;
  logic        goal_on;
  logic [4:0]  goal_index;

  goal_sprite_fetch #(
    .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(14), .IDX_W(5), .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .goal_x(goal_x), .goal_y(goal_y), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_valid(pixel_valid), .read_address(read_address),
    .rom_data(rom_data), .goal_on(goal_on), .goal_index(goal_index)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite ROM: one-cycle registered read.
  logic [4:0] mem [0:16383];
  always @(posedge Clk) rom_data <= mem[read_address];

  typedef struct {bit hit; int addr;} exp_t;
  typedef struct {int y; int x; int ea;} probe_t;

  exp_t h0, h1, h2;
  bit   armed;
  int   mgx, mgy;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic cycle(input bit rst, input bit fs, input bit pv, input int x, input int y);
    int ea, eo, ei;
    Reset_n = ~rst; frame_start = fs; pixel_valid = pv;
    DrawX = 10'(x); DrawY = 10'(y);
    h2 = h1; h1 = h0;
    if (rst) begin
      armed = 0;
      h0 = '{0, 0}; h1.hit = 0; h2.hit = 0;
    end else if (fs) begin
      armed = 1; mgx = int'(goal_x); mgy = int'(goal_y);
      h0 = '{0, 0};
    end else begin
      h0.hit  = armed && pv && (y >= mgy) && (y - mgy < H) && (x >= mgx) && (x - mgx < W);
      h0.addr = h0.hit ? (y - mgy) * W + (x - mgx) : 0;
    end
    @(posedge Clk); #1;
    ea = h0.hit ? h0.addr : 0;
    eo = (h2.hit && mem[h2.addr] != 0) ? 1 : 0;
    ei = eo ? int'(mem[h2.addr]) : 0;
    chk("read_address", int'(read_address), ea);
    chk("goal_on", int'(goal_on), eo);
    chk("goal_index", int'(goal_index), ei);
  endtask

  task automatic line(input int y, input int x0, input int x1, input int nblank);
    for (int x = x0; x <= x1; x++) cycle(0, 0, 1, x, y);
    for (int b = 0; b < nblank; b++) cycle(0, 0, 0, 0, y);
  endtask

  task automatic start_frame(input int gx, input int gy);
    goal_x = 10'(gx); goal_y = 10'(gy);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic rand_frame();
    int gx, gy, x0, x1;
    gx = int'($urandom_range(0, 639));
    gy = int'($urandom_range(0, 360));
    start_frame(gx, gy);
    for (int y = (gy > 0 ? gy - 1 : 0); y <= gy + H + 1; y++) begin
      if ($urandom_range(0, 1) == 0) x0 = (gx > 5 ? gx - 5 : 0) + int'($urandom_range(0, W));
      else x0 = int'($urandom_range(0, 639));
      if (x0 > 639) x0 = 639;
      x1 = x0 + int'($urandom_range(0, 13));
      if (x1 > 639) x1 = 639;
      if ($urandom_range(0, 7) == 0) begin
        goal_x = 10'($urandom_range(0, 639));
        goal_y = 10'($urandom_range(0, 479));
      end
      line(y, x0, x1, int'($urandom_range(2, 3)));
    end
  endtask

  initial begin
    probe_t tbl [12];
    int n;
    tbl = '{'{50, 100, 0},    '{50, 99, 0},     '{50, 101, 1},
            '{51, 110, 115},  '{60, 150, 1100}, '{70, 120, 2120},
            '{70, 121, 2121}, '{100, 204, 5354},'{100, 205, 0},
            '{159, 100, 11445},'{159, 204, 11549},'{160, 150, 0}};
    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    mem[0] = 5'd7; mem[2120] = 5'd0; mem[2121] = 5'd3;
    h0 = '{0, 0}; h1 = '{0, 0}; h2 = '{0, 0};
    armed = 0; mgx = 0; mgy = 0;
    goal_x = 10'd100; goal_y = 10'd50;
    Reset_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; DrawX = '0; DrawY = '0;

    // Reset held with active video, then two cycles after release: no hits.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 120, 60);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 121 + i, 60);
    chk("reset_goal_on", int'(goal_on), 0);
    cycle(0, 0, 0, 0, 60);

    // Table-driven probes at goal (100,50): top-left, row advance, last row, transparency.
    start_frame(100, 50);
    for (int y = 48; y <= 161; y++) begin
      n = 0;
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].y == y) begin
          cycle(0, 0, 1, tbl[i].x, y);
          chk("tbl_addr", int'(read_address), tbl[i].ea);
          n++;
        end
      end
      if (n == 0) cycle(0, 0, 1, 300, y);
      line(y, 1, 0, 2);
    end

    // Right-edge clip; goal_x change mid-frame must not take effect.
    start_frame(600, 0);
    line(0, 595, 639, 2);
    goal_x = 10'd10;
    for (int x = 5; x <= 20; x++) cycle(0, 0, 1, x, 1);
    line(1, 595, 639, 2);
    line(2, 600, 610, 2);
    start_frame(10, 0);
    line(0, 5, 20, 2);
    line(1, 5, 20, 2);

    // frame_start on the same cycle as end-of-line inside the sprite.
    start_frame(200, 10);
    line(10, 198, 210, 2);
    line(11, 198, 210, 0);
    goal_x = 10'd200; goal_y = 10'd11;
    cycle(0, 1, 0, 0, 11);
    cycle(0, 0, 0, 0, 11);
    line(11, 198, 210, 2);
    line(12, 198, 210, 2);

    // Reset mid-sprite: in-flight pixels dropped, no hits until next frame_start.
    start_frame(100, 50);
    for (int y = 48; y <= 59; y++) line(y, 150, 155, 2);
    for (int x = 140; x <= 145; x++) cycle(0, 0, 1, x, 60);
    cycle(1, 0, 1, 146, 60);
    cycle(1, 0, 1, 147, 60);
    line(60, 148, 150, 2);
    for (int y = 61; y <= 63; y++) line(y, 150, 155, 2);
    start_frame(100, 50);
    for (int y = 48; y <= 52; y++) line(y, 98, 110, 2);

    // Randomized frames against the geometric model.
    for (int f = 0; f < 4; f++) rand_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
